mult_share_arb: RTL and testbench
=================================

# mult_share_arb

Shared fixed-point multiplier with a round-robin arbiter for the FM stereo pipeline. It time-multiplexes one pipelined signed multiplier among up to NUM_REQ requesters, such as the pilot squarer, the L/R gain stages and the demod gain. Each requester gets its dequantized product back on a shared result bus, marked by a one-hot valid. The block sits beside the FIR/demod chain in the top level and replaces per-stage multiplier instances.

## Interface
- DATA_WIDTH, 32, operand/result width, signed two's complement
- NUM_REQ, 4, number of requesters, 2..8
- MULT_LATENCY, 3, cycles from grant to result, ≥1
- FRAC_BITS, 10, fixed-point fraction bits (matches the IQ quantize width)

Ports:
- clock  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-high
- req  in  NUM_REQ  per-requester request, level
- op_a  in  NUM_REQ×DATA_WIDTH  per-requester multiplicand
- op_b  in  NUM_REQ×DATA_WIDTH  per-requester multiplier
- gnt  out  NUM_REQ  one-hot grant, combinational, at most one bit set
- rsp_valid  out  NUM_REQ  one-hot result strobe, registered
- rsp_data  out  DATA_WIDTH  result, valid only while a rsp_valid bit is set
- busy  out  1  high while any operation is in flight

## Operation
- **Request.** A requester raises req[i] and holds op_a[i]/op_b[i] stable until it samples gnt[i]=1.
- **Acceptance.** The operation is accepted on the rising edge where gnt[i]=1. The requester may drop req, or present a new operation, in the next cycle.
- **Grant selection.** gnt goes to the first asserted req at or after the round-robin pointer rr_ptr, scanning upward modulo NUM_REQ.
- **Pointer update.** On a grant to i, rr_ptr ← (i+1) mod NUM_REQ. With no grant, rr_ptr holds.
- **Throughput.** One new operation can be accepted every cycle. The pipeline never stalls, and there is no response backpressure: requesters must consume rsp_data in the rsp_valid cycle.
- **Tag tracking.** A one-hot tag carrying the granted index travels alongside the operands through MULT_LATENCY stages. rsp_valid is that tag at the output stage.
- **Arithmetic.**
  - full = signed op_a × signed op_b, 2·DATA_WIDTH bits.
  - shifted = full >>> FRAC_BITS (arithmetic shift, truncates toward −∞).
  - rsp_data = shifted[DATA_WIDTH-1:0], unless saturation is enabled (see Configuration).
- **busy** = OR of all pipeline tag bits.
- **Reset values:** gnt=0 (req is ignored while reset is high), rsp_valid=0, rsp_data=0, busy=0, rr_ptr=0, all pipeline tags cleared.
- **Reset mid-operation:** all in-flight operations are discarded and no rsp_valid is produced for them. The requester must re-request after reset.
- **Simultaneous events:** a grant in cycle n and a result for another operation in the same cycle are independent. A requester may have up to MULT_LATENCY operations outstanding; results return in grant order.

## Timing
- gnt depends combinationally on req and rr_ptr. It must not depend on op_a/op_b.
- Grant edge = cycle 0. rsp_valid[i] and rsp_data are registered outputs, high for exactly one cycle at cycle MULT_LATENCY.
- Latency is fixed at MULT_LATENCY, independent of load. Sustained throughput is 1 result per cycle.
- Fairness: with all requests held continuously, each requester is granted exactly once in every NUM_REQ consecutive cycles.
- MULT_LATENCY=1 means a single register after the multiply. Extra stages are placed before the multiply for retiming.

## Configuration
- Macro MULT_SHARE_ARB_SATURATE_EN.
- **Defined:** if shifted exceeds the signed DATA_WIDTH range, rsp_data clamps to 0x7FFF…F (positive overflow) or 0x8000…0 (negative overflow). Clamp selection is done in the output stage; latency is unchanged.
- **Undefined:** rsp_data is the plain truncation shifted[DATA_WIDTH-1:0], with wrap-around.

## Structure
- Shared package `fm_pkg`: DATA_WIDTH and FRAC_BITS defaults, a `mul_tag_t` one-hot typedef, and the saturation bound constants.
- Sub-module `rr_arbiter`: req, rr_ptr → gnt and next pointer. It is purely combinational and reusable for FIFO read arbitration.
- The top of `mult_share_arb` holds the pointer register, the operand/tag pipeline, the multiply, the shift and the optional saturation.

## Test plan
- **Basic positive product.** Single request on port 0, op_a=0x00000400, op_b=0x00000800 → gnt[0] in the same cycle; rsp_valid[0] 3 cycles later with rsp_data=0x00000800; busy high for 3 cycles.
- **Negative product.** Port 2, op_a=0xFFFFFC00, op_b=0x00000C00 → rsp_valid[2] with rsp_data=0xFFFFF400.
- **Round-robin fairness.** All four req held for 8 cycles → gnt sequence 0,1,2,3,0,1,2,3; rsp_valid repeats the same sequence 3 cycles later, one result per cycle.
- **Pointer skip.** From reset, req=4'b1010 held → gnt 1,3,1,3. Then drop req[3] → gnt stays on 1 every cycle.
- **Overflow.** op_a=op_b=0x7FFFFFFF → 0x7FFFFFFF with MULT_SHARE_ARB_SATURATE_EN defined; 0xFFC00000 without it.
- **Reset mid-operation.** Grants in cycles 0 and 1, reset asserted in cycle 2 → no rsp_valid in cycles 3–4; rr_ptr=0 afterwards; busy=0 in the first cycle after reset deasserts.

Source files
------------

// File: rtl/fm_pkg.sv
// Shared FM pipeline definitions: default datapath widths, the one-hot
// requester tag carried through the shared multiplier, and saturation bounds.
package fm_pkg;

  localparam int FM_DATA_WIDTH = 32;
  localparam int FM_FRAC_BITS  = 10;
  localparam int FM_MAX_REQ    = 8;

  // One-hot requester tag; sized for the largest supported requester count,
  // unused upper bits stay zero.
  typedef logic [FM_MAX_REQ-1:0] mul_tag_t;

  // Saturation bounds for the default data width.
  localparam logic [FM_DATA_WIDTH-1:0] FM_SAT_MAX = {1'b0, {(FM_DATA_WIDTH-1){1'b1}}};
  localparam logic [FM_DATA_WIDTH-1:0] FM_SAT_MIN = {1'b1, {(FM_DATA_WIDTH-1){1'b0}}};

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first asserted request at or after the
// pointer (scanning upward, wrapping) and returns the pointer that follows
// the winner. Purely combinational so it can be reused elsewhere.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int PTR_W = $clog2(N)
) (
  input  logic [N-1:0]     i_req,
  input  logic [PTR_W-1:0] i_ptr,
  output logic [N-1:0]     o_gnt,
  output logic [PTR_W-1:0] o_ptr_next
);

  // Scan from the pointer, take the first hit; pointer holds when idle.
  always_comb begin
    logic             w_found;
    logic [PTR_W-1:0] w_idx;
    o_gnt      = '0;
    o_ptr_next = i_ptr;
    w_found    = 1'b0;
    w_idx      = '0;
    for (int k = 0; k < N; k++) begin
      w_idx = PTR_W'((int'(i_ptr) + k) % N);
      if (!w_found && i_req[w_idx]) begin
        o_gnt[w_idx] = 1'b1;
        o_ptr_next   = PTR_W'((int'(w_idx) + 1) % N);
        w_found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mult_share_arb.sv
// Shared signed fixed-point multiplier time-multiplexed among NUM_REQ
// requesters by a round-robin arbiter. A one-hot tag follows each operation
// through MULT_LATENCY stages and becomes the result strobe.
// Optional feature: define MULT_SHARE_ARB_SATURATE_EN to clamp results that
// exceed the signed DATA_WIDTH range instead of wrapping.
module mult_share_arb
  import fm_pkg::*;
#(
  parameter int DATA_WIDTH   = FM_DATA_WIDTH,
  parameter int NUM_REQ      = 4,
  parameter int MULT_LATENCY = 3,
  parameter int FRAC_BITS    = FM_FRAC_BITS
) (
  input  logic                          i_clock,
  input  logic                          i_reset,
  input  logic [NUM_REQ-1:0]            i_req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] i_op_a,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] i_op_b,
  output logic [NUM_REQ-1:0]            o_gnt,
  output logic [NUM_REQ-1:0]            o_rsp_valid,
  output logic [DATA_WIDTH-1:0]         o_rsp_data,
  output logic                          o_busy
);

  localparam int PTR_W = $clog2(NUM_REQ);

  logic [PTR_W-1:0]               r_rr_ptr;
  logic [PTR_W-1:0]               w_rr_ptr_next;
  logic [NUM_REQ-1:0]             w_req_masked;
  logic [NUM_REQ-1:0]             w_gnt;
  logic [DATA_WIDTH-1:0]          w_masked_a [NUM_REQ];
  logic [DATA_WIDTH-1:0]          w_masked_b [NUM_REQ];
  logic signed [DATA_WIDTH-1:0]   w_sel_a;
  logic signed [DATA_WIDTH-1:0]   w_sel_b;
  logic signed [DATA_WIDTH-1:0]   w_mul_a;
  logic signed [DATA_WIDTH-1:0]   w_mul_b;
  logic signed [2*DATA_WIDTH-1:0] w_full;
  logic signed [2*DATA_WIDTH-1:0] w_shift;
  logic [DATA_WIDTH-1:0]          w_res;
  mul_tag_t                       w_gnt_tag;
  mul_tag_t                       r_tag [MULT_LATENCY];
  logic [DATA_WIDTH-1:0]          r_rsp_data;
  logic                           w_busy;

  // Requests are ignored while reset is held so nothing is accepted then.
  assign w_req_masked = i_reset ? '0 : i_req;

  rr_arbiter #(
    .N     (NUM_REQ),
    .PTR_W (PTR_W)
  ) u_arb (
    .i_req      (w_req_masked),
    .i_ptr      (r_rr_ptr),
    .o_gnt      (w_gnt),
    .o_ptr_next (w_rr_ptr_next)
  );

  assign o_gnt = w_gnt;

  // Round-robin pointer; the arbiter already holds it when nothing is granted.
  always_ff @(posedge i_clock) begin
    if (i_reset) r_rr_ptr <= '0;
    else         r_rr_ptr <= w_rr_ptr_next;
  end

  // Per-requester operands gated by their grant bit, then OR-combined below.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_opmask
    assign w_masked_a[gi] = w_gnt[gi] ? i_op_a[gi*DATA_WIDTH +: DATA_WIDTH] : '0;
    assign w_masked_b[gi] = w_gnt[gi] ? i_op_b[gi*DATA_WIDTH +: DATA_WIDTH] : '0;
  end

  // Grant is one-hot, so OR-ing the gated operands selects the winner.
  always_comb begin
    w_sel_a = '0;
    w_sel_b = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_sel_a = w_sel_a | w_masked_a[k];
      w_sel_b = w_sel_b | w_masked_b[k];
    end
  end

  // Widen the grant vector into the tag type carried down the pipeline.
  always_comb begin
    w_gnt_tag              = '0;
    w_gnt_tag[NUM_REQ-1:0] = w_gnt;
  end

  // Extra latency goes in front of the multiply so synthesis can retime it.
  if (MULT_LATENCY > 1) begin : g_pre
    logic signed [DATA_WIDTH-1:0] r_pre_a [MULT_LATENCY-1];
    logic signed [DATA_WIDTH-1:0] r_pre_b [MULT_LATENCY-1];

    // Operand delay line ahead of the multiplier.
    always_ff @(posedge i_clock) begin
      if (i_reset) begin
        for (int k = 0; k < MULT_LATENCY-1; k++) begin
          r_pre_a[k] <= '0;
          r_pre_b[k] <= '0;
        end
      end else begin
        r_pre_a[0] <= w_sel_a;
        r_pre_b[0] <= w_sel_b;
        for (int k = 1; k < MULT_LATENCY-1; k++) begin
          r_pre_a[k] <= r_pre_a[k-1];
          r_pre_b[k] <= r_pre_b[k-1];
        end
      end
    end

    assign w_mul_a = r_pre_a[MULT_LATENCY-2];
    assign w_mul_b = r_pre_b[MULT_LATENCY-2];
  end else begin : g_direct
    assign w_mul_a = w_sel_a;
    assign w_mul_b = w_sel_b;
  end

  // Full-precision signed product, then drop the fraction bits (floor).
  assign w_full  = (2*DATA_WIDTH)'(w_mul_a) * (2*DATA_WIDTH)'(w_mul_b);
  assign w_shift = w_full >>> FRAC_BITS;

`ifdef MULT_SHARE_ARB_SATURATE_EN
  localparam logic signed [2*DATA_WIDTH-1:0] SAT_HI_EXT =
    (2*DATA_WIDTH)'({1'b0, {(DATA_WIDTH-1){1'b1}}});
  localparam logic signed [2*DATA_WIDTH-1:0] SAT_LO_EXT =
    {{(DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  // Clamp out-of-range results to the nearest representable bound.
  always_comb begin
    if (w_shift > SAT_HI_EXT)      w_res = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    else if (w_shift < SAT_LO_EXT) w_res = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    else                           w_res = DATA_WIDTH'(w_shift);
  end
`else
  // Plain truncation; out-of-range results wrap.
  always_comb begin
    w_res = DATA_WIDTH'(w_shift);
  end
`endif

  // Tag pipeline: the grant vector travels alongside the operands.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      for (int k = 0; k < MULT_LATENCY; k++) r_tag[k] <= '0;
    end else begin
      r_tag[0] <= w_gnt_tag;
      for (int k = 1; k < MULT_LATENCY; k++) r_tag[k] <= r_tag[k-1];
    end
  end

  // Output data register, aligned with the last tag stage.
  always_ff @(posedge i_clock) begin
    if (i_reset) r_rsp_data <= '0;
    else         r_rsp_data <= w_res;
  end

  // Busy while any stage carries a live tag.
  always_comb begin
    w_busy = 1'b0;
    for (int k = 0; k < MULT_LATENCY; k++) w_busy = w_busy | (|r_tag[k]);
  end

  assign o_rsp_valid = r_tag[MULT_LATENCY-1][NUM_REQ-1:0];
  assign o_rsp_data  = r_rsp_data;
  assign o_busy      = w_busy;

endmodule

// File: tb/tb_mult_share_arb.sv
// Self-checking bench for mult_share_arb: directed steps followed by random
// traffic, all compared against a queue-based reference model.
module tb_mult_share_arb;

  localparam int W = 32;
  localparam int N = 4;
  localparam int L = 3;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [N*W-1:0] op_a;
  logic [N*W-1:0] op_b;
  logic [N-1:0]   gnt;
  logic [N-1:0]   rsp_valid;
  logic [W-1:0]   rsp_data;
  logic           busy;

  always #5 clk = ~clk;

  mult_share_arb #(
    .DATA_WIDTH   (W),
    .NUM_REQ      (N),
    .MULT_LATENCY (L),
    .FRAC_BITS    (10)
  ) dut (
    .i_clock     (clk),
    .i_reset     (rst),
    .i_req       (req),
    .i_op_a      (op_a),
    .i_op_b      (op_b),
    .o_gnt       (gnt),
    .o_rsp_valid (rsp_valid),
    .o_rsp_data  (rsp_data),
    .o_busy      (busy)
  );

  typedef struct {
    int           due;
    logic [N-1:0] vld;
    logic [W-1:0] data;
  } exp_t;

  exp_t         q[$];
  int           ptr;
  int           edge_cnt;
  int           total;
  int           bad;
  int           gnt_log[$];
  int           rsp_log[$];
  logic [W-1:0] last_data;
  logic [N-1:0] last_vld;
  logic [N-1:0] last_gnt;
  logic         last_busy;
  int           busy_hits;
  int           rsp_hits;

  // Product from the arithmetic rules: signed multiply, floor shift, wrap or clamp.
  function automatic logic [W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
    longint full;
    longint sh;
    full = longint'($signed(a)) * longint'($signed(b));
    sh   = full >>> 10;
`ifdef MULT_SHARE_ARB_SATURATE_EN
    if (sh > 64'sd2147483647)  return 32'h7FFF_FFFF;
    if (sh < -64'sd2147483648) return 32'h8000_0000;
`endif
    return sh[W-1:0];
  endfunction

  function automatic int idx_of(input logic [N-1:0] v);
    for (int k = 0; k < N; k++) if (v[k]) return k;
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    op_a[i*W +: W] = a;
    op_b[i*W +: W] = b;
  endtask

  // One clock: check outputs mid-cycle, then advance the model at the edge.
  task automatic step();
    int           gidx;
    logic [N-1:0] eg;
    logic [N-1:0] ev;
    logic [W-1:0] ed;
    logic         in_flight;
    @(negedge clk);
    gidx = -1;
    eg   = '0;
    if (!rst) begin
      for (int k = 0; k < N; k++) begin
        int j;
        j = (ptr + k) % N;
        if (gidx < 0 && req[j]) gidx = j;
      end
    end
    if (gidx >= 0) eg[gidx] = 1'b1;
    in_flight = (q.size() > 0);
    ev = '0;
    ed = '0;
    if (q.size() > 0 && q[0].due == edge_cnt) begin
      ev = q[0].vld;
      ed = q[0].data;
      q.delete(0);
    end
    chk("gnt", W'(gnt), W'(eg));
    chk("rsp_valid", W'(rsp_valid), W'(ev));
    chk("busy", W'(busy), W'(in_flight));
    if (ev != '0) chk("rsp_data", rsp_data, ed);
    if (gnt != '0) gnt_log.push_back(idx_of(gnt));
    if (rsp_valid != '0) begin
      rsp_log.push_back(idx_of(rsp_valid));
      last_data = rsp_data;
      last_vld  = rsp_valid;
      rsp_hits++;
    end
    if (busy) busy_hits++;
    last_gnt  = gnt;
    last_busy = busy;
    @(posedge clk);
    edge_cnt++;
    if (rst) begin
      q.delete();
      ptr = 0;
    end else if (gidx >= 0) begin
      exp_t e;
      e.due  = edge_cnt + L - 1;
      e.vld  = eg;
      e.data = model(op_a[gidx*W +: W], op_b[gidx*W +: W]);
      q.push_back(e);
      ptr = (gidx + 1) % N;
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    step();
    rst = 1'b0;
  endtask

  task automatic flush();
    req = '0;
    repeat (L + 1) step();
  endtask

  initial begin
    logic [W-1:0] exp_ovf;
    logic [W-1:0] exp_novf;
    total = 0; bad = 0; ptr = 0; edge_cnt = 0;
    busy_hits = 0; rsp_hits = 0;
    last_data = '0; last_vld = '0; last_gnt = '0; last_busy = 1'b0;
    rst = 1'b1; req = '0; op_a = '0; op_b = '0;
    @(posedge clk);
    #1;

    // Reset state: outputs quiet, data register cleared.
    step();
    chk("reset_rsp_data", rsp_data, 32'h0);
    rst = 1'b0;

    // Basic positive product on port 0.
    busy_hits = 0;
    set_op(0, 32'h0000_0400, 32'h0000_0800);
    req = 4'b0001;
    step();
    req = '0;
    repeat (5) step();
    chk("basic_data", last_data, 32'h0000_0800);
    chk("basic_vld", W'(last_vld), 32'h1);
    chk("basic_busy_cycles", W'(busy_hits), 32'd3);

    // Negative product on port 2.
    set_op(2, 32'hFFFF_FC00, 32'h0000_0C00);
    req = 4'b0100;
    step();
    flush();
    chk("neg_data", last_data, 32'hFFFF_F400);
    chk("neg_vld", W'(last_vld), 32'h4);

    // Round-robin fairness with all requests held.
    do_reset();
    gnt_log.delete();
    rsp_log.delete();
    for (int i = 0; i < N; i++) set_op(i, $urandom, $urandom);
    req = 4'b1111;
    repeat (8) step();
    flush();
    chk("rr_gnt_count", W'(gnt_log.size()), 32'd8);
    chk("rr_rsp_count", W'(rsp_log.size()), 32'd8);
    for (int i = 0; i < 8; i++) begin
      if (i < gnt_log.size()) chk("rr_gnt_seq", W'(gnt_log[i]), W'(i % N));
      if (i < rsp_log.size()) chk("rr_rsp_seq", W'(rsp_log[i]), W'(i % N));
    end

    // Pointer skip over idle requesters.
    do_reset();
    gnt_log.delete();
    req = 4'b1010;
    repeat (4) step();
    req = 4'b0010;
    repeat (3) step();
    chk("skip_count", W'(gnt_log.size()), 32'd7);
    for (int i = 0; i < 7; i++) begin
      if (i < gnt_log.size()) chk("skip_seq", W'(gnt_log[i]), (i < 4 && (i % 2) == 1) ? 32'd3 : 32'd1);
    end
    flush();

    // Positive and negative overflow.
`ifdef MULT_SHARE_ARB_SATURATE_EN
    exp_ovf  = 32'h7FFF_FFFF;
    exp_novf = 32'h8000_0000;
`else
    exp_ovf  = 32'hFFC0_0000;
    exp_novf = 32'h0020_0000;
`endif
    set_op(0, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
    req = 4'b0001;
    step();
    flush();
    chk("ovf_pos", last_data, exp_ovf);
    set_op(0, 32'h8000_0000, 32'h7FFF_FFFF);
    req = 4'b0001;
    step();
    flush();
    chk("ovf_neg", last_data, exp_novf);

    // Reset while two operations are in flight.
    do_reset();
    set_op(0, 32'h0001_0000, 32'h0000_0400);
    set_op(1, 32'h0002_0000, 32'h0000_0400);
    req = 4'b0001;
    step();
    req = 4'b0010;
    step();
    req = '0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    rsp_hits = 0;
    step();
    chk("busy_after_rst", W'(last_busy), 32'h0);
    step();
    chk("no_rsp_after_rst", W'(rsp_hits), 32'd0);
    req = 4'b1111;
    step();
    chk("ptr_after_rst", W'(last_gnt), 32'h1);
    flush();

    // Random traffic with occasional resets.
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(0, 49) == 0);
      req = N'($urandom_range(0, 15));
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 1) == 1)
          set_op(i, $urandom, $urandom);
        else
          set_op(i, W'($signed($urandom_range(0, 16383)) - 8192),
                    W'($signed($urandom_range(0, 16383)) - 8192));
      end
      step();
    end
    rst = 1'b0;
    flush();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
